ttt_turn_controller: RTL and testbench
======================================

// Module: ttt_turn_controller
// PURPOSE
//  Turn sequencer and move arbiter in front of game_logic. Takes move requests from two
//  player front-ends (X, O), enforces turn order and legality, and issues exactly one
//  single-cycle move strobe per accepted turn.
//  Waits for game_logic to settle, samples game_over/winner, then either passes the turn
//  or ends the game. Owns game start/restart via a one-cycle clear pulse to game_logic.
// PARAMETERS
//  FIRST_PLAYER    2'd1  player who moves first after start (1 = X, 2 = O)
//  SETTLE_CYCLES   2     cycles from mv_valid to sampling gl_game_over/gl_winner (>=1)
//  TIMEOUT_CYCLES  1000  idle cycles allowed per turn (used only with TURN_TIMEOUT_EN)
// PORTS
//  clk           in   1  clock
//  reset         in   1  synchronous, active-high reset
//  start         in   1  begin or restart a game (honoured in IDLE and DONE only)
//  req_x, req_o  in   1  move request from player X / O (one-cycle pulse or held level)
//  pos_x, pos_o  in   4  requested cell 0..8, valid with the matching req
//  gl_game_over  in   1  game_over from game_logic
//  gl_winner     in   2  winner from game_logic (1 X, 2 O, 3 draw)
//  gl_clear      out  1  one-cycle reset pulse to game_logic
//  mv_valid      out  1  one-cycle move strobe to game_logic
//  mv_player     out  2  player of the issued move
//  mv_pos        out  4  cell of the issued move
//  ack_x, ack_o  out  1  one-cycle pulse: request accepted
//  nack_x,nack_o out  1  one-cycle pulse: request rejected
//  cur_player    out  2  player whose turn it is; 0 when no game is active
//  move_count    out  4  accepted moves this game, 0..9
//  timeout       out  1  one-cycle pulse: turn forfeited for inactivity
//  done          out  1  high in DONE
//  result        out  2  final result, valid while done (1 X, 2 O, 3 draw)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; occupancy mask=0; all counters=0.
//  States: IDLE, CLEAR, WAIT_MOVE, ISSUE, SETTLE, DONE.
//  IDLE/DONE + start -> CLEAR. CLEAR lasts one cycle:
//    gl_clear=1, occ=0, move_count=0, result=0, cur_player=FIRST_PLAYER. Then -> WAIT_MOVE.
//  WAIT_MOVE: evaluates requests every cycle; each ack/nack is registered (1 cycle later).
//    - Requester is not the current player -> nack for that requester.
//    - Current player with pos>8 or occ[pos]=1 -> nack; stay in WAIT_MOVE.
//    - Current player, legal cell -> ack; latch pos; set occ[pos]; -> ISSUE.
//    - req_x and req_o in the same cycle: current player is handled as above;
//      the other player is nacked.
//  ISSUE: one cycle. mv_valid=1, mv_player=cur_player, mv_pos=latched pos;
//    move_count+1. -> SETTLE.
//  SETTLE: wait SETTLE_CYCLES cycles, then sample gl_game_over and gl_winner:
//    gl_game_over=1 -> DONE, result=gl_winner;
//    else move_count==9 -> DONE, result=3;
//    else cur_player toggles 1<->2 -> WAIT_MOVE.
//    Requests arriving in ISSUE or SETTLE are nacked.
//  DONE: done=1; result held; cur_player=0; all requests nacked; only start leaves.
//  mv_player/mv_pos hold their last values outside ISSUE; mv_valid never exceeds 1 cycle.
//  start outside IDLE/DONE is ignored. reset at any time, including mid-ISSUE,
//    forces reset values on the next edge.
// CONFIGURATION
//  TURN_TIMEOUT_EN defined:
//    - WAIT_MOVE counts cycles without an ack, in a $clog2(TIMEOUT_CYCLES+1)-bit counter.
//    - Count reaches TIMEOUT_CYCLES -> timeout pulse; turn passes to the other player;
//      move_count and occ are unchanged; counter clears.
//    - Counter also clears on ack and on entry to WAIT_MOVE.
//  TURN_TIMEOUT_EN undefined: no counter; timeout tied 0; WAIT_MOVE waits indefinitely.
// TESTING
//  1. reset; start; req_x pos=4 -> gl_clear pulse; ack_x; mv_valid with player=1, pos=4;
//     after settle cur_player=2, move_count=1.
//  2. X has played 4; req_o pos=4 -> nack_o, no mv_valid. Then req_x in O's turn -> nack_x.
//     Then req_o pos=9 -> nack_o.
//  3. Same-cycle req_x pos=0 and req_o pos=1 on X's turn -> ack_x and nack_o;
//     only cell 0 is issued.
//  4. X plays 0,1,2 against O at 3,4; model asserts game_over, winner=1 ->
//     done=1, result=1; later reqs nacked; start restarts with move_count=0.
//  5. Nine legal moves with gl_game_over held 0 -> done=1, result=3, move_count=9.
//  6. TURN_TIMEOUT_EN, TIMEOUT_CYCLES=8: no request for 8 cycles on X's turn ->
//     timeout pulse, cur_player=2, move_count unchanged. reset mid-SETTLE -> all reset values.

Source files
------------

// File: rtl/ttt_turn_controller_if.sv
// Purpose : bundles the player request/ack lines and the game_logic move/result
//           lines of the tic-tac-toe turn controller into one interface.
// Ports   : master = environment side (players + game_logic), slave = controller.
//   start                    begin/restart a game
//   req_x/req_o, pos_x/pos_o player move requests and requested cell 0..8
//   gl_game_over, gl_winner  status back from game_logic (winner 1 X, 2 O, 3 draw)
//   gl_clear                 one-cycle clear pulse to game_logic
//   mv_valid/mv_player/mv_pos one-cycle move strobe with its payload
//   ack_*/nack_*             one-cycle accept/reject pulses per player
//   cur_player, move_count   whose turn it is (0 = no game) and moves this game
//   timeout, done, result    forfeit pulse, game-over flag, final result
interface ttt_turn_controller_if;
  logic       start;
  logic       req_x;
  logic       req_o;
  logic [3:0] pos_x;
  logic [3:0] pos_o;
  logic       gl_game_over;
  logic [1:0] gl_winner;
  logic       gl_clear;
  logic       mv_valid;
  logic [1:0] mv_player;
  logic [3:0] mv_pos;
  logic       ack_x;
  logic       ack_o;
  logic       nack_x;
  logic       nack_o;
  logic [1:0] cur_player;
  logic [3:0] move_count;
  logic       timeout;
  logic       done;
  logic [1:0] result;

  modport master (
    output start, req_x, req_o, pos_x, pos_o, gl_game_over, gl_winner,
    input  gl_clear, mv_valid, mv_player, mv_pos, ack_x, ack_o, nack_x, nack_o,
           cur_player, move_count, timeout, done, result
  );

  modport slave (
    input  start, req_x, req_o, pos_x, pos_o, gl_game_over, gl_winner,
    output gl_clear, mv_valid, mv_player, mv_pos, ack_x, ack_o, nack_x, nack_o,
           cur_player, move_count, timeout, done, result
  );
endinterface

// File: rtl/ttt_turn_controller.sv
// Purpose : turn sequencer and move arbiter in front of game_logic (players X and O).
// Latency : ack/nack and mv_valid one cycle after the request; result sampled
//           SETTLE_CYCLES cycles after mv_valid.
// Backpressure: none; requests that cannot be taken are nacked, never stalled.
// Ports   : clk, reset (synchronous, active-high); bus = ttt_turn_controller_if.slave
//           (start, req_x/o, pos_x/o, gl_game_over, gl_winner in; gl_clear, mv_valid,
//           mv_player, mv_pos, ack_x/o, nack_x/o, cur_player, move_count, timeout,
//           done, result out). All outputs are registered.
// Option  : define TURN_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYCLES idle cycles;
//           without it timeout is tied 0 and WAIT_MOVE waits indefinitely.
module ttt_turn_controller #(
  parameter logic [1:0] FIRST_PLAYER   = 2'd1,
  parameter int         SETTLE_CYCLES  = 2,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  reset,
  ttt_turn_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_MOVE, S_ISSUE, S_SETTLE, S_DONE
  } state_t;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);

  state_t        state;
  logic [8:0]    occ;
  logic [SW-1:0] settle_cnt;
  logic          gl_clear_q;
  logic          mv_valid_q;
  logic [1:0]    mv_player_q;
  logic [3:0]    mv_pos_q;
  logic          ack_x_q, ack_o_q, nack_x_q, nack_o_q;
  logic [1:0]    cur_player_q;
  logic [3:0]    move_count_q;
  logic          done_q;
  logic [1:0]    result_q;

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
  logic          timeout_q;
`else
  wire unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Move legality. occ is zero-extended so any 4-bit pos indexes safely.
  logic [15:0] occ_ext;
  logic        x_legal, o_legal, x_accept, o_accept, any_accept;
  logic [3:0]  acc_pos;
  logic [1:0]  other_player;

  always_comb begin
    occ_ext      = {7'd0, occ};
    x_legal      = (bus.pos_x <= 4'd8) && !occ_ext[bus.pos_x];
    o_legal      = (bus.pos_o <= 4'd8) && !occ_ext[bus.pos_o];
    // Only the player on turn can be accepted, so at most one accept per cycle.
    x_accept     = (state == S_WAIT_MOVE) && bus.req_x && (cur_player_q == 2'd1) && x_legal;
    o_accept     = (state == S_WAIT_MOVE) && bus.req_o && (cur_player_q == 2'd2) && o_legal;
    any_accept   = x_accept || o_accept;
    acc_pos      = x_accept ? bus.pos_x : bus.pos_o;
    other_player = (cur_player_q == 2'd1) ? 2'd2 : 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      occ          <= '0;
      settle_cnt   <= '0;
      gl_clear_q   <= 1'b0;
      mv_valid_q   <= 1'b0;
      mv_player_q  <= '0;
      mv_pos_q     <= '0;
      ack_x_q      <= 1'b0;
      ack_o_q      <= 1'b0;
      nack_x_q     <= 1'b0;
      nack_o_q     <= 1'b0;
      cur_player_q <= '0;
      move_count_q <= '0;
      done_q       <= 1'b0;
      result_q     <= '0;
`ifdef TURN_TIMEOUT_EN
      to_cnt       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      gl_clear_q <= 1'b0;
      mv_valid_q <= 1'b0;
      // Any request not accepted this cycle, in any state, is rejected.
      ack_x_q    <= x_accept;
      ack_o_q    <= o_accept;
      nack_x_q   <= bus.req_x && !x_accept;
      nack_o_q   <= bus.req_o && !o_accept;
`ifdef TURN_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif

      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state        <= S_CLEAR;
            gl_clear_q   <= 1'b1;
            occ          <= '0;
            move_count_q <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
            cur_player_q <= FIRST_PLAYER;
          end
        end

        S_CLEAR: begin
          state <= S_WAIT_MOVE;
`ifdef TURN_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end

        S_WAIT_MOVE: begin
          if (any_accept) begin
            // The move strobe is set up on the accept edge so it lands in ISSUE.
            state        <= S_ISSUE;
            occ          <= occ | (9'd1 << acc_pos);
            mv_valid_q   <= 1'b1;
            mv_player_q  <= cur_player_q;
            mv_pos_q     <= acc_pos;
            move_count_q <= move_count_q + 4'd1;
`ifdef TURN_TIMEOUT_EN
            to_cnt       <= '0;
`endif
          end
`ifdef TURN_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            // Forfeit: the turn passes, the board and move count stay as they are.
            timeout_q    <= 1'b1;
            cur_player_q <= other_player;
            to_cnt       <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end

        S_ISSUE: begin
          state      <= S_SETTLE;
          settle_cnt <= SW'(1);
        end

        S_SETTLE: begin
          // settle_cnt is the number of cycles elapsed since mv_valid.
          if (settle_cnt == SETTLE_LAST) begin
            if (bus.gl_game_over) begin
              state        <= S_DONE;
              done_q       <= 1'b1;
              result_q     <= bus.gl_winner;
              cur_player_q <= '0;
            end else if (move_count_q == 4'd9) begin
              state        <= S_DONE;
              done_q       <= 1'b1;
              result_q     <= 2'd3;
              cur_player_q <= '0;
            end else begin
              state        <= S_WAIT_MOVE;
              cur_player_q <= other_player;
`ifdef TURN_TIMEOUT_EN
              to_cnt       <= '0;
`endif
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gl_clear   = gl_clear_q;
  assign bus.mv_valid   = mv_valid_q;
  assign bus.mv_player  = mv_player_q;
  assign bus.mv_pos     = mv_pos_q;
  assign bus.ack_x      = ack_x_q;
  assign bus.ack_o      = ack_o_q;
  assign bus.nack_x     = nack_x_q;
  assign bus.nack_o     = nack_o_q;
  assign bus.cur_player = cur_player_q;
  assign bus.move_count = move_count_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
`ifdef TURN_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Directed bench for ttt_turn_controller: turn order, legality, arbitration,
// win/draw endings, restart, reset mid-settle and (when enabled) turn timeout.
module tb_ttt_turn_controller;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ttt_turn_controller_if bus();

  ttt_turn_controller #(
    .FIRST_PLAYER(2'd1),
    .SETTLE_CYCLES(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot taken by play(): outputs in the cycle after the request, plus
  // the number of mv_valid cycles seen across the whole move.
  logic       s_ack_x, s_ack_o, s_nack_x, s_nack_o, s_mv_valid;
  logic [1:0] s_mv_player;
  logic [3:0] s_mv_pos, s_move_count;
  int         s_pulses;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(1);
  endtask

  // One request cycle, then three more cycles: the controller is back in
  // WAIT_MOVE (or DONE) afterwards when the move was accepted.
  task automatic play(input logic rx, input logic [3:0] px, input logic ro, input logic [3:0] po);
    bus.req_x = rx; bus.pos_x = px;
    bus.req_o = ro; bus.pos_o = po;
    cyc(1);
    s_ack_x = bus.ack_x;   s_ack_o = bus.ack_o;
    s_nack_x = bus.nack_x; s_nack_o = bus.nack_o;
    s_mv_valid = bus.mv_valid; s_mv_player = bus.mv_player;
    s_mv_pos = bus.mv_pos; s_move_count = bus.move_count;
    s_pulses = bus.mv_valid ? 1 : 0;
    bus.req_x = 1'b0; bus.req_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (bus.mv_valid) s_pulses++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.gl_clear, bus.mv_valid, bus.ack_x, bus.ack_o, bus.nack_x, bus.nack_o, bus.timeout, bus.done} !== 8'd0) begin
      errors++; $display("FAIL reset_pulses: got %b required 00000000",
        {bus.gl_clear, bus.mv_valid, bus.ack_x, bus.ack_o, bus.nack_x, bus.nack_o, bus.timeout, bus.done});
    end
    checks++;
    if ({bus.cur_player, bus.move_count, bus.result, bus.mv_player, bus.mv_pos} !== 14'd0) begin
      errors++; $display("FAIL reset_values: got %h required 0",
        {bus.cur_player, bus.move_count, bus.result, bus.mv_player, bus.mv_pos});
    end
  endtask

  task automatic test_first_move();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    checks++;
    if (bus.gl_clear !== 1'b1 || bus.cur_player !== 2'd1) begin
      errors++; $display("FAIL clear_pulse: gl_clear=%b cur=%0d required 1/1", bus.gl_clear, bus.cur_player);
    end
    cyc(1);
    checks++;
    if (bus.gl_clear !== 1'b0) begin
      errors++; $display("FAIL clear_one_cycle: got %b required 0", bus.gl_clear);
    end
    play(1'b1, 4'd4, 1'b0, 4'd0);
    checks++;
    if (!(s_ack_x === 1'b1 && s_mv_valid === 1'b1 && s_mv_player === 2'd1 && s_mv_pos === 4'd4)) begin
      errors++; $display("FAIL first_move: ack=%b mv=%b player=%0d pos=%0d required 1 1 1 4",
        s_ack_x, s_mv_valid, s_mv_player, s_mv_pos);
    end
    checks++;
    if (s_pulses !== 1) begin
      errors++; $display("FAIL mv_single_cycle: got %0d cycles required 1", s_pulses);
    end
    checks++;
    if (bus.cur_player !== 2'd2 || bus.move_count !== 4'd1) begin
      errors++; $display("FAIL turn_pass: cur=%0d count=%0d required 2 1", bus.cur_player, bus.move_count);
    end
  endtask

  task automatic test_illegal();
    play(1'b0, 4'd0, 1'b1, 4'd4);
    checks++;
    if (s_nack_o !== 1'b1 || s_ack_o !== 1'b0 || s_pulses !== 0) begin
      errors++; $display("FAIL occupied_cell: nack_o=%b ack_o=%b mv=%0d required 1 0 0", s_nack_o, s_ack_o, s_pulses);
    end
    play(1'b1, 4'd0, 1'b0, 4'd0);
    checks++;
    if (s_nack_x !== 1'b1 || s_ack_x !== 1'b0 || s_pulses !== 0) begin
      errors++; $display("FAIL wrong_turn: nack_x=%b ack_x=%b mv=%0d required 1 0 0", s_nack_x, s_ack_x, s_pulses);
    end
    play(1'b0, 4'd0, 1'b1, 4'd9);
    checks++;
    if (s_nack_o !== 1'b1 || s_pulses !== 0 || bus.cur_player !== 2'd2 || bus.move_count !== 4'd1) begin
      errors++; $display("FAIL pos_range: nack_o=%b mv=%0d cur=%0d count=%0d required 1 0 2 1",
        s_nack_o, s_pulses, bus.cur_player, bus.move_count);
    end
    play(1'b0, 4'd0, 1'b1, 4'd8);
    checks++;
    if (s_ack_o !== 1'b1 || s_mv_player !== 2'd2 || s_mv_pos !== 4'd8 || bus.cur_player !== 2'd1) begin
      errors++; $display("FAIL o_move: ack_o=%b player=%0d pos=%0d cur=%0d required 1 2 8 1",
        s_ack_o, s_mv_player, s_mv_pos, bus.cur_player);
    end
  endtask

  task automatic test_same_cycle();
    play(1'b1, 4'd0, 1'b1, 4'd1);
    checks++;
    if (s_ack_x !== 1'b1 || s_nack_o !== 1'b1 || s_ack_o !== 1'b0 || s_nack_x !== 1'b0) begin
      errors++; $display("FAIL arb_ack: ack_x=%b nack_o=%b ack_o=%b nack_x=%b required 1 1 0 0",
        s_ack_x, s_nack_o, s_ack_o, s_nack_x);
    end
    checks++;
    if (s_pulses !== 1 || s_mv_pos !== 4'd0 || s_mv_player !== 2'd1 || bus.move_count !== 4'd3) begin
      errors++; $display("FAIL arb_issue: mv=%0d pos=%0d player=%0d count=%0d required 1 0 1 3",
        s_pulses, s_mv_pos, s_mv_player, bus.move_count);
    end
    // start mid-game is ignored
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    checks++;
    if (bus.gl_clear !== 1'b0 || bus.move_count !== 4'd3 || bus.cur_player !== 2'd2) begin
      errors++; $display("FAIL start_ignored: clear=%b count=%0d cur=%0d required 0 3 2",
        bus.gl_clear, bus.move_count, bus.cur_player);
    end
  endtask

  task automatic test_win();
    do_reset();
    start_game();
    play(1'b1, 4'd0, 1'b0, 4'd0);
    play(1'b0, 4'd0, 1'b1, 4'd3);
    play(1'b1, 4'd1, 1'b0, 4'd0);
    play(1'b0, 4'd0, 1'b1, 4'd4);
    bus.gl_game_over = 1'b1;
    bus.gl_winner = 2'd1;
    play(1'b1, 4'd2, 1'b0, 4'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 2'd1 || bus.cur_player !== 2'd0 || bus.move_count !== 4'd5) begin
      errors++; $display("FAIL win: done=%b result=%0d cur=%0d count=%0d required 1 1 0 5",
        bus.done, bus.result, bus.cur_player, bus.move_count);
    end
    bus.gl_game_over = 1'b0;
    bus.gl_winner = 2'd0;
    play(1'b0, 4'd0, 1'b1, 4'd5);
    checks++;
    if (s_nack_o !== 1'b1 || s_pulses !== 0 || bus.done !== 1'b1 || bus.result !== 2'd1) begin
      errors++; $display("FAIL done_nack: nack_o=%b mv=%0d done=%b result=%0d required 1 0 1 1",
        s_nack_o, s_pulses, bus.done, bus.result);
    end
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    checks++;
    if (bus.gl_clear !== 1'b1 || bus.move_count !== 4'd0 || bus.done !== 1'b0 || bus.result !== 2'd0 || bus.cur_player !== 2'd1) begin
      errors++; $display("FAIL restart: clear=%b count=%0d done=%b result=%0d cur=%0d required 1 0 0 0 1",
        bus.gl_clear, bus.move_count, bus.done, bus.result, bus.cur_player);
    end
    cyc(1);
  endtask

  task automatic test_draw();
    logic [3:0] cells [9];
    int         bad;
    cells = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) play(1'b1, cells[i], 1'b0, 4'd0);
      else            play(1'b0, 4'd0, 1'b1, cells[i]);
      if (s_pulses != 1 || s_mv_pos != cells[i] || s_move_count != 4'(i + 1)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL draw_moves: got %0d bad moves required 0", bad);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 2'd3 || bus.move_count !== 4'd9 || bus.cur_player !== 2'd0) begin
      errors++; $display("FAIL draw: done=%b result=%0d count=%0d cur=%0d required 1 3 9 0",
        bus.done, bus.result, bus.move_count, bus.cur_player);
    end
  endtask

  task automatic test_reset_mid_settle();
    start_game();
    bus.req_x = 1'b1; bus.pos_x = 4'd6;
    cyc(1);
    bus.req_x = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    checks++;
    if ({bus.mv_valid, bus.done, bus.ack_x, bus.gl_clear} !== 4'd0 ||
        {bus.cur_player, bus.move_count, bus.result, bus.mv_player, bus.mv_pos} !== 14'd0) begin
      errors++; $display("FAIL reset_mid_settle: pulses=%b values=%h required 0 0",
        {bus.mv_valid, bus.done, bus.ack_x, bus.gl_clear},
        {bus.cur_player, bus.move_count, bus.result, bus.mv_player, bus.mv_pos});
    end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_timeout();
    do_reset();
    start_game();
`ifdef TURN_TIMEOUT_EN
    cyc(7);
    checks++;
    if (bus.timeout !== 1'b0 || bus.cur_player !== 2'd1) begin
      errors++; $display("FAIL timeout_early: timeout=%b cur=%0d required 0 1", bus.timeout, bus.cur_player);
    end
    cyc(1);
    checks++;
    if (bus.timeout !== 1'b1 || bus.cur_player !== 2'd2 || bus.move_count !== 4'd0) begin
      errors++; $display("FAIL timeout: timeout=%b cur=%0d count=%0d required 1 2 0",
        bus.timeout, bus.cur_player, bus.move_count);
    end
    cyc(1);
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got %b required 0", bus.timeout);
    end
`else
    cyc(20);
    checks++;
    if (bus.timeout !== 1'b0 || bus.cur_player !== 2'd1) begin
      errors++; $display("FAIL no_timeout: timeout=%b cur=%0d required 0 1", bus.timeout, bus.cur_player);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.req_x = 1'b0; bus.req_o = 1'b0;
    bus.pos_x = 4'd0; bus.pos_o = 4'd0;
    bus.gl_game_over = 1'b0;
    bus.gl_winner = 2'd0;
    test_reset();
    test_first_move();
    test_illegal();
    test_same_cycle();
    test_win();
    test_draw();
    test_reset_mid_settle();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
